// File: rtl/rtc_prog_sequencer.sv
// RTC programming batch sequencer: turns one request into ordered RTC register writes.
// Optional RTC_TIMER_PROG_EN adds three timer-register writes after the date writes.
module rtc_prog_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_req,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hour,
  input  logic [7:0] day,
  input  logic [7:0] month,
  input  logic [7:0] year,
`ifdef RTC_TIMER_PROG_EN
  input  logic [7:0] tmr_sec,
  input  logic [7:0] tmr_min,
  input  logic [7:0] tmr_hour,
`endif
  input  logic       wr_done,
  output logic       wr_start,
  output logic [7:0] wr_dir,
  output logic [7:0] wr_dato,
  output logic       busy,
  output logic       prog_done,
  output logic       err_timeout
);

`ifdef RTC_TIMER_PROG_EN
  localparam int N = 9;
`else
  localparam int N = 6;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    N_LAST = 4'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [7:0]    snap [N];
  logic [7:0]    cur;

  // Date registers live at 0x21.., timer registers at 0x41..
  function automatic logic [7:0] addr_of(input logic [3:0] i);
    logic [7:0] i8;
    i8 = {4'h0, i};
    if (i < 4'd6) return 8'h21 + i8;
    return 8'h3b + i8;
  endfunction

  always_comb begin
    cur = 8'h00;
    for (int k = 0; k < N; k++)
      if (idx == 4'(k)) cur = snap[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= 4'd0;
      tcnt        <= '0;
      gcnt        <= '0;
      wr_start    <= 1'b0;
      wr_dir      <= 8'h00;
      wr_dato     <= 8'h00;
      busy        <= 1'b0;
      prog_done   <= 1'b0;
      err_timeout <= 1'b0;
      for (int k = 0; k < N; k++)
        snap[k] <= 8'h00;
    end else begin
      prog_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (prog_req) begin
            snap[0]     <= sec;
            snap[1]     <= min;
            snap[2]     <= hour;
            snap[3]     <= day;
            snap[4]     <= month;
            snap[5]     <= year;
`ifdef RTC_TIMER_PROG_EN
            snap[6]     <= tmr_sec;
            snap[7]     <= tmr_min;
            snap[8]     <= tmr_hour;
`endif
            err_timeout <= 1'b0;
            idx         <= 4'd0;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wr_dir   <= addr_of(idx);
          wr_dato  <= cur;
          wr_start <= 1'b1;
          tcnt     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout
          if (wr_done) begin
            wr_start <= 1'b0;
            wr_dir   <= 8'h00;
            wr_dato  <= 8'h00;
            idx      <= idx + 4'd1;
            gcnt     <= '0;
            state    <= S_GAP;
          end else if (tcnt == T_LAST) begin
            wr_start    <= 1'b0;
            wr_dir      <= 8'h00;
            wr_dato     <= 8'h00;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == G_LAST) begin
            gcnt <= '0;
            if (idx == N_LAST) begin
              prog_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_prog_sequencer.sv
// Directed bench for rtc_prog_sequencer with a small RTC write-engine model.
// Covers nominal batch, snapshot, timeout, ignored requests and mid-batch reset.
module tb_rtc_prog_sequencer;

  localparam int TO  = 16;
  localparam int GAP = 2;
`ifdef RTC_TIMER_PROG_EN
  localparam int NW = 9;
`else
  localparam int NW = 6;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_req = 1'b0;
  logic       wr_done = 1'b0;
  logic [7:0] sec = 8'h00, min = 8'h00, hour = 8'h00;
  logic [7:0] day = 8'h00, month = 8'h00, year = 8'h00;
`ifdef RTC_TIMER_PROG_EN
  logic [7:0] tmr_sec = 8'h00, tmr_min = 8'h00, tmr_hour = 8'h00;
`endif
  logic       wr_start;
  logic [7:0] wr_dir;
  logic [7:0] wr_dato;
  logic       busy;
  logic       prog_done;
  logic       err_timeout;

  rtc_prog_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_req   (prog_req),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .day        (day),
    .month      (month),
    .year       (year),
`ifdef RTC_TIMER_PROG_EN
    .tmr_sec    (tmr_sec),
    .tmr_min    (tmr_min),
    .tmr_hour   (tmr_hour),
`endif
    .wr_done    (wr_done),
    .wr_start   (wr_start),
    .wr_dir     (wr_dir),
    .wr_dato    (wr_dato),
    .busy       (busy),
    .prog_done  (prog_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] log_dir [0:255];
  logic [7:0] log_dat [0:255];
  int         low_before [0:255];
  int         log_n = 0;
  int         done_cnt = 0;
  int         stable_err = 0;
  int         last_high = 0;
  int         high_run = 0;
  int         low_run = 0;
  int         cd = 0;
  int         stall_at = -1;
  logic       prev_start = 1'b0;
  logic [7:0] hold_dir = 8'h00;
  logic [7:0] hold_dat = 8'h00;

  logic [7:0] exp_addr [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] exp_dat [0:8];

  // Engine model and bus monitor; sole writer of the log and wr_done
  always @(negedge clk) begin
    wr_done = 1'b0;
    if (wr_start && !prev_start) begin
      if (log_n < 256) begin
        log_dir[log_n]    = wr_dir;
        log_dat[log_n]    = wr_dato;
        low_before[log_n] = low_run;
      end
      hold_dir = wr_dir;
      hold_dat = wr_dato;
      cd       = (log_n == stall_at) ? 0 : 5;
      log_n++;
      high_run = 1;
    end else if (wr_start) begin
      high_run++;
      if (wr_dir !== hold_dir || wr_dato !== hold_dat) stable_err++;
    end
    if (!wr_start) begin
      if (prev_start) begin
        last_high = high_run;
        low_run   = 0;
      end
      low_run++;
      cd = 0;
    end
    if (wr_start && cd > 0) begin
      cd--;
      if (cd == 0) wr_done = 1'b1;
    end
    if (prog_done) done_cnt++;
    prev_start = wr_start;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] s, m, h, d, mo, y);
    sec = s; min = m; hour = h; day = d; month = mo; year = y;
    exp_dat[0] = s; exp_dat[1] = m; exp_dat[2] = h;
    exp_dat[3] = d; exp_dat[4] = mo; exp_dat[5] = y;
  endtask

  task automatic set_tmr(input logic [7:0] s, m, h);
`ifdef RTC_TIMER_PROG_EN
    tmr_sec = s; tmr_min = m; tmr_hour = h;
`endif
    exp_dat[6] = s; exp_dat[7] = m; exp_dat[8] = h;
  endtask

  // Inputs are scrambled right after the request to prove the snapshot
  task automatic scramble();
    sec = 8'h00; min = 8'h00; hour = 8'h00;
    day = 8'h00; month = 8'h00; year = 8'h00;
`ifdef RTC_TIMER_PROG_EN
    tmr_sec = 8'h00; tmr_min = 8'h00; tmr_hour = 8'h00;
`endif
  endtask

  task automatic run_batch(input bit spam);
    int c;
    bit seen;
    seen = 1'b0;
    @(negedge clk); #1 prog_req = 1'b1;
    @(negedge clk); #1 prog_req = 1'b0;
    scramble();
    for (c = 0; c < 2000; c++) begin
      if (busy) seen = 1'b1;
      if (seen && !busy) break;
      prog_req = spam && busy && c[0];
      @(negedge clk); #1;
    end
    prog_req = 1'b0;
    check("batch_ends", 32'(c < 2000), 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_writes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("addr%0d", i), log_dir[base+i], exp_addr[i]);
      check($sformatf("data%0d", i), log_dat[base+i], exp_dat[i]);
      if (i > 0)
        check($sformatf("gap%0d", i), 32'(low_before[base+i] >= GAP), 1);
    end
  endtask

  initial begin
    int base;
    int d0;
    int c;

    repeat (3) @(negedge clk);
    check("rst_start", wr_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", prog_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_dir", wr_dir, 0);
    check("rst_dato", wr_dato, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal batch with snapshot check
    set_data(8'h45, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
    set_tmr(8'h10, 8'h20, 8'h01);
    base = log_n; d0 = done_cnt;
    run_batch(1'b0);
    check("nom_writes", log_n - base, NW);
    check_writes(base, NW);
    check("nom_done", done_cnt - d0, 1);
    check("nom_busy", busy, 0);
    check("nom_err", err_timeout, 0);
    check("nom_start", wr_start, 0);

    // Engine stalls on the third write
    set_data(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    set_tmr(8'h07, 8'h08, 8'h09);
    base = log_n; d0 = done_cnt;
    stall_at = base + 2;
    run_batch(1'b0);
    stall_at = -1;
    check("to_writes", log_n - base, 3);
    check("to_addr2", log_dir[base+2], 8'h23);
    check("to_high", last_high, TO);
    check("to_err", err_timeout, 1);
    check("to_done", done_cnt - d0, 0);
    check("to_busy", busy, 0);
    check("to_start", wr_start, 0);

    // Recovery batch clears the sticky error
    set_data(8'h59, 8'h58, 8'h23, 8'h31, 8'h12, 8'h99);
    set_tmr(8'h33, 8'h44, 8'h55);
    base = log_n; d0 = done_cnt;
    run_batch(1'b0);
    check("rec_writes", log_n - base, NW);
    check_writes(base, NW);
    check("rec_done", done_cnt - d0, 1);
    check("rec_err", err_timeout, 0);

    // Requests while busy are ignored
    set_data(8'h11, 8'h22, 8'h08, 8'h28, 8'h02, 8'h24);
    set_tmr(8'h05, 8'h06, 8'h07);
    base = log_n; d0 = done_cnt;
    run_batch(1'b1);
    repeat (20) @(negedge clk);
    #1;
    check("spam_writes", log_n - base, NW);
    check_writes(base, NW);
    check("spam_done", done_cnt - d0, 1);
    check("spam_busy", busy, 0);

    // Reset during the 0x23 write
    set_data(8'h12, 8'h34, 8'h21, 8'h01, 8'h01, 8'h00);
    base = log_n; d0 = done_cnt;
    @(negedge clk); #1 prog_req = 1'b1;
    @(negedge clk); #1 prog_req = 1'b0;
    for (c = 0; c < 300; c++) begin
      if (log_n >= base + 3) break;
      @(negedge clk); #1;
    end
    check("rst_reach", 32'(c < 300), 1);
    check("rst_addr2", log_dir[base+2], 8'h23);
    check("rst_mid_start_pre", wr_start, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_start", wr_start, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_dir", wr_dir, 0);
    check("rst_mid_dato", wr_dato, 0);
    @(negedge clk); reset = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("rst_quiet", log_n - base, 3);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_busy", busy, 0);
    check("stable", stable_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
